// File: rtl/scope_pix_if.sv
// Pixel-write port of the 320x240 VGA framebuffer: one (x, y, colour) write per plot strobe.
interface scope_pix_if;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic       plot;

  modport master (output x, y, color, plot);
  modport slave  (input  x, y, color, plot);
endinterface

// File: rtl/scope_display.sv
// Multi-channel oscilloscope sweep generator: per column it latches every channel, maps it to a
// screen row and sweeps the column top to bottom, drawing each trace as a prev->cur row segment.
module scope_display #(
  parameter int          XMAX         = 319,
  parameter int          YMAX         = 239,
  parameter int          YMID         = 120,
  parameter int          DATA_W       = 16,
  parameter int          NCH          = 2,
  parameter int          SHIFT        = 8,
  parameter int          SWEEP_DELAY  = 10000,
  parameter int          TRIG_TIMEOUT = 2000000,
  parameter int          GRID         = 40,
  parameter logic [11:0] COLORS       = {3'b100, 3'b010, 3'b110, 3'b011},
  parameter logic [2:0]  GRID_COLOR   = 3'b001
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  freeze,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic                  grid_en,
  input  logic [NCH*DATA_W-1:0] data,
  scope_pix_if.master           pix
);

  localparam int DW = $clog2(SWEEP_DELAY + 2);
  localparam int TW = $clog2(TRIG_TIMEOUT + 2);
  localparam int GW = $clog2(GRID + 1);

  typedef enum logic [1:0] {S_ARM, S_WAIT, S_LATCH, S_PLOT} state_t;

  state_t            state_q, state_d;
  logic [8:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [DW-1:0]     delay_q, delay_d;
  logic [TW-1:0]     trig_q, trig_d;
  logic [GW-1:0]     xmod_q, xmod_d, ymod_q, ymod_d;
  logic [7:0]        cur_row_q [NCH];
  logic [7:0]        cur_row_d [NCH];
  logic [7:0]        prev_row_q [NCH];
  logic [7:0]        prev_row_d [NCH];
  logic [DATA_W-1:0] ch0_last_q;
  logic [7:0]        latch_row [NCH];
  logic [NCH-1:0]    lit;
  logic              rising;
  logic [2:0]        pix_color;

  // Positive samples plot upward: row = YMID - clamp(sample >>> SHIFT).
  function automatic logic [7:0] row_of(input logic [DATA_W-1:0] smp);
    logic signed [DATA_W-1:0] sh;
    int                       s;
    sh = $signed(smp) >>> SHIFT;
    s  = int'(sh);
    if (s > YMID)
      s = YMID;
    else if (s < YMID - YMAX)
      s = YMID - YMAX;
    return 8'(YMID - s);
  endfunction

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign latch_row[gi] = row_of(data[gi*DATA_W +: DATA_W]);
      assign lit[gi] = (cur_row_q[gi] <= prev_row_q[gi])
                     ? (y_q >= cur_row_q[gi]  && y_q <= prev_row_q[gi])
                     : (y_q >= prev_row_q[gi] && y_q <= cur_row_q[gi]);
    end
  endgenerate

  assign rising = ($signed(ch0_last_q) < $signed(trig_level)) &&
                  ($signed(data[DATA_W-1:0]) >= $signed(trig_level));

  always_ff @(posedge clock) begin
    ch0_last_q <= data[DATA_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= S_ARM;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    delay_d    = delay_q;
    trig_d     = trig_q;
    xmod_d     = xmod_q;
    ymod_d     = ymod_q;
    cur_row_d  = cur_row_q;
    prev_row_d = prev_row_q;
    case (state_q)
      S_ARM: begin
        // Freeze has priority, so a coincident trigger edge is dropped.
        if (!freeze) begin
          case (mode)
            2'd1: if (rising) state_d = S_WAIT;
            2'd2: begin
              if (rising || trig_q == TW'(TRIG_TIMEOUT)) begin
                state_d = S_WAIT;
                trig_d  = '0;
              end else begin
                trig_d = trig_q + TW'(1);
              end
            end
            default: state_d = S_WAIT;
          endcase
        end
      end
      S_WAIT: begin
        if (delay_q == DW'(SWEEP_DELAY)) begin
          if (!freeze) begin
            delay_d = '0;
            state_d = S_LATCH;
          end
        end else begin
          delay_d = delay_q + DW'(1);
        end
      end
      S_LATCH: begin
        for (int i = 0; i < NCH; i++) begin
          cur_row_d[i] = latch_row[i];
          if (x_q == 9'd0)
            prev_row_d[i] = latch_row[i];
        end
        y_d     = '0;
        ymod_d  = '0;
        state_d = S_PLOT;
      end
      S_PLOT: begin
        if (y_q == 8'(YMAX)) begin
          prev_row_d = cur_row_q;
          y_d        = '0;
          ymod_d     = '0;
          if (x_q == 9'(XMAX)) begin
            x_d     = '0;
            xmod_d  = '0;
            state_d = S_ARM;
          end else begin
            x_d     = x_q + 9'd1;
            xmod_d  = (xmod_q == GW'(GRID - 1)) ? '0 : xmod_q + GW'(1);
            state_d = S_WAIT;
          end
        end else begin
          y_d    = y_q + 8'd1;
          ymod_d = (ymod_q == GW'(GRID - 1)) ? '0 : ymod_q + GW'(1);
        end
      end
      default: state_d = S_ARM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      delay_q <= '0;
      trig_q  <= '0;
      xmod_q  <= '0;
      ymod_q  <= '0;
      for (int i = 0; i < NCH; i++) begin
        cur_row_q[i]  <= 8'(YMID);
        prev_row_q[i] <= 8'(YMID);
      end
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      delay_q    <= delay_d;
      trig_q     <= trig_d;
      xmod_q     <= xmod_d;
      ymod_q     <= ymod_d;
      cur_row_q  <= cur_row_d;
      prev_row_q <= prev_row_d;
    end
  end

  // Lowest-index lit channel wins: scan downward so it is assigned last.
  always_comb begin
    pix_color = '0;
    if (state_q == S_PLOT) begin
      if (|lit) begin
        for (int i = NCH - 1; i >= 0; i--)
          if (lit[i])
            pix_color = COLORS[3*i +: 3];
      end else if (grid_en && (xmod_q == '0 || ymod_q == '0 || y_q == 8'(YMID))) begin
        pix_color = GRID_COLOR;
      end
    end
  end

  assign pix.x     = x_q;
  assign pix.y     = y_q;
  assign pix.color = pix_color;
  assign pix.plot  = (state_q == S_PLOT);

endmodule

// File: tb/tb_scope_display.sv
// Directed-plus-random bench for scope_display with a short sweep delay and a 45-column frame.
module tb_scope_display;
  localparam int SD = 4;
  localparam int TT = 20;
  localparam int XM = 44;

  logic        clock      = 1'b0;
  logic        reset      = 1'b1;
  logic        freeze     = 1'b0;
  logic [1:0]  mode       = 2'd0;
  logic [15:0] trig_level = 16'h0000;
  logic        grid_en    = 1'b0;
  logic [31:0] data       = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cur [2];
  logic [2:0] ch_col [4] = '{3'b011, 3'b110, 3'b010, 3'b100};

  scope_pix_if pix ();

  scope_display #(.XMAX(XM), .SWEEP_DELAY(SD), .TRIG_TIMEOUT(TT)) dut (
    .clock      (clock),
    .reset      (reset),
    .freeze     (freeze),
    .mode       (mode),
    .trig_level (trig_level),
    .grid_en    (grid_en),
    .data       (data),
    .pix        (pix)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int row_of(input logic [15:0] d);
    int s;
    s = int'($signed(d)) >>> 8;
    if (s > 120) s = 120;
    if (s < -119) s = -119;
    return 120 - s;
  endfunction

  function automatic logic [2:0] exp_color(input int xx, input int yy, input int p [2],
                                           input int c [2], input logic g);
    for (int ch = 0; ch < 2; ch++) begin
      int lo, hi;
      lo = (p[ch] < c[ch]) ? p[ch] : c[ch];
      hi = (p[ch] < c[ch]) ? c[ch] : p[ch];
      if (yy >= lo && yy <= hi) return ch_col[ch];
    end
    if (g && (xx % 40 == 0 || yy % 40 == 0 || yy == 120)) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [15:0] rand_sample();
    int r;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    r = int'($urandom_range(0, 66560)) - 33280;
    return 16'(r);
  endfunction

  task automatic wait_plot(input string tag, input int exp);
    int n = 0;
    while (pix.plot !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check(tag, n, exp);
  endtask

  task automatic count_idle(input string tag, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      if (pix.plot !== 1'b0) seen++;
      tick();
    end
    check(tag, seen, 0);
  endtask

  // Drive one column's samples, wait for its sweep, then check npix pixels against the model.
  task automatic run_col(input int xe, input logic [15:0] d0, input logic [15:0] d1,
                         input logic g, input int gap, input int npix,
                         input bit scramble, input int frz_at);
    int c [2];
    int p [2];
    logic [2:0] col;
    data    = {d1, d0};
    grid_en = g;
    wait_plot($sformatf("gap_x%0d", xe), gap);
    c[0] = row_of(d0);
    c[1] = row_of(d1);
    for (int ch = 0; ch < 2; ch++) p[ch] = (xe == 0) ? c[ch] : m_cur[ch];
    for (int yy = 0; yy < npix; yy++) begin
      col = exp_color(xe, yy, p, c, g);
      check($sformatf("pix_x%0d_y%0d", xe, yy), {pix.plot, pix.x, pix.y, pix.color},
            {1'b1, 9'(xe), 8'(yy), col});
      if (scramble) data = $urandom;
      if (yy == frz_at) freeze = 1'b1;
      tick();
    end
    m_cur = c;
    $display("column x=%0d d0=%h d1=%h rows prev=%0d/%0d cur=%0d/%0d grid=%0d pixels=%0d",
             xe, d0, d1, p[0], p[1], c[0], c[1], g, npix);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g;
    repeat (3) tick();
    check("rst_plot",  pix.plot,  0);
    check("rst_x",     pix.x,     0);
    check("rst_y",     pix.y,     0);
    check("rst_color", pix.color, 0);
    reset = 1'b0;
    m_cur = '{120, 120};

    // Frame 1, free-running: first plot 7 cycles after reset, then directed and random columns.
    run_col(0, 16'h0000, 16'h0000, 1'b0, SD + 3, 240, 1'b0, -1);
    run_col(1, 16'h1400, 16'h0000, 1'b0, SD + 2, 240, 1'b1, -1);
    run_col(2, 16'hEC00, 16'h0000, 1'b0, SD + 2, 240, 1'b1, -1);
    run_col(3, 16'h7FFF, 16'h8000, 1'b0, SD + 2, 240, 1'b1, -1);
    for (int xx = 4; xx <= XM; xx++) begin
      g = (xx == 40) ? 1'b1 : 1'($urandom_range(0, 1));
      run_col(xx, rand_sample(), rand_sample(), g, SD + 2, 240, 1'b1, -1);
    end

    // Frame 2: wrap back to x=0, then switch to auto mode mid-frame.
    trig_level = 16'h7FFF;
    run_col(0, rand_sample(), rand_sample(), 1'b1, SD + 3, 240, 1'b1, -1);
    mode = 2'd2;
    for (int xx = 1; xx <= XM; xx++) begin
      g = 1'($urandom_range(0, 1));
      run_col(xx, rand_sample(), rand_sample(), g, SD + 2, 240, 1'b1, -1);
    end

    // Frame 3: auto-mode timeout start, freeze raised mid-column, then reset mid-plot.
    run_col(0, 16'h0000, rand_sample(), 1'b0, TT + 1 + SD + 2, 240, 1'b0, 100);
    mode = 2'd0;
    count_idle("freeze_hold", 30);
    freeze = 1'b0;
    run_col(1, rand_sample(), rand_sample(), 1'b1, 2, 50, 1'b0, -1);
    reset = 1'b1;
    tick();
    check("midrst_plot",  pix.plot,  0);
    check("midrst_x",     pix.x,     0);
    check("midrst_y",     pix.y,     0);
    check("midrst_color", pix.color, 0);

    // Normal mode: no sweep without a rising edge; a trigger coinciding with freeze is lost.
    mode       = 2'd1;
    trig_level = 16'h0000;
    data       = {16'h0000, 16'hFF9C};
    tick();
    reset = 1'b0;
    count_idle("normal_no_trig", 300);
    freeze   = 1'b1;
    data     = {16'h0000, 16'h0064};
    tick();
    freeze = 1'b0;
    count_idle("freeze_eats_trig", 40);
    data = {16'h0000, 16'hFF9C};
    tick();
    run_col(0, 16'h0064, 16'h0000, 1'b0, SD + 3, 240, 1'b0, -1);
    run_col(1, 16'hEC00, 16'h1400, 1'b1, SD + 2, 240, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
